// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial WIDTH-bit ALU. It evaluates one bit per
// clock, LSB first, through a single-bit slice and rides the carry between bits.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request, accepted only while ready=1 (IDLE)
//   op[2:0]       000 pass A, 001 NOT A, 010 ADD, 011 SUB, 100 OR, 101 AND,
//                 110 SLT, 111 zero
//   a, b          operands, captured on accept
//   ready         high while idle
//   done          one-cycle completion pulse
//   result        result word, held until the next done
//   c_out         final carry (ADD/SUB only)
//   overflow      signed overflow (ADD/SUB only)
//   zero          result == 0
module serial_alu_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             v_q, v_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  // One-bit slice signals
  logic             sub_like, arith, addsub, bx, sum, cout, bit_res;
  logic [WIDTH-1:0] res_w;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      v_q        <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sh_q       <= sh_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      v_q        <= v_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Next-state, bit slice and output assembly
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sh_d       = sh_q;
    op_d       = op_q;
    carry_d    = carry_q;
    v_d        = v_q;
    done_d     = 1'b0;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    res_w      = sh_q;

    // SUB and SLT add the inverted B with a carry seed of 1
    sub_like = (op_q == OP_SUB) || (op_q == OP_SLT);
    addsub   = (op_q == OP_ADD) || (op_q == OP_SUB);
    arith    = addsub || (op_q == OP_SLT);
    bx       = b_q[0] ^ sub_like;
    sum      = a_q[0] ^ bx ^ carry_q;
    cout     = (a_q[0] & bx) | (carry_q & (a_q[0] ^ bx));

    unique case (op_q)
      OP_PASS: bit_res = a_q[0];
      OP_NOT:  bit_res = ~a_q[0];
      OP_ADD,
      OP_SUB,
      OP_SLT:  bit_res = sum;
      OP_OR:   bit_res = a_q[0] | b_q[0];
      OP_AND:  bit_res = a_q[0] & b_q[0];
      default: bit_res = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          sh_d    = '0;
          carry_d = (op == OP_SUB) || (op == OP_SLT);
          v_d     = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {bit_res, sh_q[WIDTH-1:1]};
        carry_d = arith ? cout : 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry into MSB XOR carry out of MSB
          v_d     = carry_q ^ cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // SLT: sign of the true difference = diff MSB XOR overflow
        res_w      = (op_q == OP_SLT) ? WIDTH'(sh_q[WIDTH-1] ^ v_q) : sh_q;
        result_d   = res_w;
        c_out_d    = addsub ? carry_q : 1'b0;
        overflow_d = addsub ? v_q : 1'b0;
        zero_d     = (res_w == '0);
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer (WIDTH=8). Expected results are
// computed by a word-level model, queued at accept and compared on done.
module tb_serial_alu_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = WIDTH + 1;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference model
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] s;
    e = '0;
    case (o)
      3'b000: e.res = x;
      3'b001: e.res = ~x;
      3'b010: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[7:0];
        e.c   = s[8];
        e.v   = (x[7] == y[7]) && (s[7] != x[7]);
      end
      3'b011: begin
        s     = {1'b0, x} + {1'b0, ~y} + 9'd1;
        e.res = s[7:0];
        e.c   = s[8];
        e.v   = (x[7] != y[7]) && (s[7] != x[7]);
      end
      3'b100: e.res = x | y;
      3'b101: e.res = x & y;
      3'b110: e.res = ($signed(x) < $signed(y)) ? 8'h01 : 8'h00;
      default: e.res = 8'h00;
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Issue one operation; noisy keeps start high with junk while busy
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input bit noisy);
    int   lat;
    int   wait_cnt;
    exp_t e;
    wait_cnt = 0;
    @(negedge clk);
    while (!ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_ready_low"}, 32'(ready), 32'd0);
    lat = 0;
    while (lat < 30) begin
      if (noisy && !ready) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 7));
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(e.res));
      chk({tag, "_c_out"}, 32'(c_out), 32'(e.c));
      chk({tag, "_overflow"}, 32'(overflow), 32'(e.v));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(result), 32'(e.res));
    end else begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_cv", 32'({c_out, overflow}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op("add_7f_01", 3'b010, 8'h7F, 8'h01, 1'b0);
    do_op("sub_05_05", 3'b011, 8'h05, 8'h05, 1'b0);
    do_op("sub_00_01", 3'b011, 8'h00, 8'h01, 1'b0);
    do_op("slt_80_01", 3'b110, 8'h80, 8'h01, 1'b0);
    do_op("slt_01_80", 3'b110, 8'h01, 8'h80, 1'b0);
    do_op("slt_7f_7f", 3'b110, 8'h7F, 8'h7F, 1'b0);
    do_op("not", 3'b001, 8'h0F, 8'h3C, 1'b0);
    do_op("or", 3'b100, 8'h0F, 8'h3C, 1'b0);
    do_op("and", 3'b101, 8'h0F, 8'h3C, 1'b0);
    do_op("zero_op", 3'b111, 8'h0F, 8'h3C, 1'b0);
    do_op("pass", 3'b000, 8'h0F, 8'h3C, 1'b0);
    do_op("add_ovf_neg", 3'b010, 8'h80, 8'hFF, 1'b0);
    do_op("noisy_sub", 3'b011, 8'h40, 8'hC1, 1'b1);
    do_op("after_noisy", 3'b100, 8'hA0, 8'h05, 1'b0);

    // Short reset pulse mid-SHIFT aborts the operation
    @(negedge clk);
    start = 1'b1;
    op    = 3'b010;
    a     = 8'h12;
    b     = 8'h34;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'h00);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_cv", 32'({c_out, overflow}), 32'd0);
    #2;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    do_op("add_ff_01", 3'b010, 8'hFF, 8'h01, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
